coproc_perf_monitor: RTL

Synthesizable cycle and bus-activity monitor for the matrix-multiplier coprocessor top level. It measures the run from the main-controller start to the status write. It counts memory reads and writes, per-processor grant cycles and per-processor stall cycles. It raises a watchdog timeout if the status write never arrives. Counters are read back through a registered select/data port, for use both in simulation and on silicon.

---
 rtl/coproc_perf_monitor.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/coproc_perf_monitor.sv
// coproc_perf_monitor
//   Cycle and bus-activity monitor for the matrix-multiplier coprocessor.
//   It measures the run from the controller's start pulse to the status write.
//   It counts memory reads and writes, plus grant and stall cycles for each
//   processor. A watchdog ends a run that never completes.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   i_Start / i_Done           run start pulse / status-write (completion)
//   i_Requests / i_Grants      per-processor request and grant vectors
//   i_Memory_Read_Enable       shared memory read strobe
//   i_Memory_Write_Enable      shared memory write strobe
//   i_Read_Select              counter index; o_Read_Data is registered, 1-cycle latency
//   o_Busy / o_Finished        state is RUN / DONE
//   o_Timeout, o_Overflow, o_Grant_Error   sticky flags, cleared on run start
//
// Build option
//   COPROC_PERF_MONITOR_STALL_EN  when defined, builds the per-processor stall
//   counters at read indices 3+N..3+2N-1. When undefined, those indices read 0.
module coproc_perf_monitor #(
  parameter int unsigned NUMBER_OF_PROCESSORS = 4,
  parameter int unsigned COUNTER_WIDTH        = 32,
  parameter int unsigned TIMEOUT_CYCLES       = 100000,
  parameter int unsigned SELECT_WIDTH         = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_Start,
  input  logic                            i_Done,
  input  logic [NUMBER_OF_PROCESSORS-1:0] i_Requests,
  input  logic [NUMBER_OF_PROCESSORS-1:0] i_Grants,
  input  logic                            i_Memory_Read_Enable,
  input  logic                            i_Memory_Write_Enable,
  input  logic [SELECT_WIDTH-1:0]         i_Read_Select,
  output logic [COUNTER_WIDTH-1:0]        o_Read_Data,
  output logic                            o_Busy,
  output logic                            o_Finished,
  output logic                            o_Timeout,
  output logic                            o_Overflow,
  output logic                            o_Grant_Error
);

  localparam int unsigned N = NUMBER_OF_PROCESSORS;
  localparam logic [COUNTER_WIDTH-1:0] MAX = '1;
  // Last cycle-counter value of a run that the watchdog allows.
  localparam logic [63:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? 64'd0 : 64'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [COUNTER_WIDTH-1:0] r_cycles, w_cycles_nxt;
  logic [COUNTER_WIDTH-1:0] r_reads, w_reads_nxt;
  logic [COUNTER_WIDTH-1:0] r_writes, w_writes_nxt;
  logic [COUNTER_WIDTH-1:0] r_grant [N];
  logic [COUNTER_WIDTH-1:0] w_grant_nxt [N];
`ifdef COPROC_PERF_MONITOR_STALL_EN
  logic [COUNTER_WIDTH-1:0] r_stall [N];
  logic [COUNTER_WIDTH-1:0] w_stall_nxt [N];
`else
  logic                     w_unused_requests;
  assign w_unused_requests = ^i_Requests;
`endif
  logic                     r_timeout, w_timeout_nxt;
  logic                     r_overflow, w_overflow_nxt;
  logic                     r_grant_error, w_grant_error_nxt;
  logic [COUNTER_WIDTH-1:0] r_read_data, w_read_data;
  logic                     w_sat_hit;

  function automatic logic [COUNTER_WIDTH-1:0] f_sat_inc(input logic [COUNTER_WIDTH-1:0] v,
                                                         input logic en);
    return (en && (v != MAX)) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    w_state_nxt       = r_state;
    w_cycles_nxt      = r_cycles;
    w_reads_nxt       = r_reads;
    w_writes_nxt      = r_writes;
    w_grant_nxt       = r_grant;
`ifdef COPROC_PERF_MONITOR_STALL_EN
    w_stall_nxt       = r_stall;
`endif
    w_timeout_nxt     = r_timeout;
    w_overflow_nxt    = r_overflow;
    w_grant_error_nxt = r_grant_error;
    w_sat_hit         = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        // Start takes priority over a coincident i_Done. The start edge clears
        // all results, so counting begins on the following cycle.
        if (i_Start) begin
          w_state_nxt       = ST_RUN;
          w_cycles_nxt      = '0;
          w_reads_nxt       = '0;
          w_writes_nxt      = '0;
          for (int unsigned k = 0; k < N; k++) begin
            w_grant_nxt[k] = '0;
`ifdef COPROC_PERF_MONITOR_STALL_EN
            w_stall_nxt[k] = '0;
`endif
          end
          w_timeout_nxt     = 1'b0;
          w_overflow_nxt    = 1'b0;
          w_grant_error_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        w_cycles_nxt = f_sat_inc(r_cycles, 1'b1);
        w_reads_nxt  = f_sat_inc(r_reads, i_Memory_Read_Enable);
        w_writes_nxt = f_sat_inc(r_writes, i_Memory_Write_Enable);
        w_sat_hit    = (w_cycles_nxt == MAX) || (w_reads_nxt == MAX) || (w_writes_nxt == MAX);
        for (int unsigned k = 0; k < N; k++) begin
          w_grant_nxt[k] = f_sat_inc(r_grant[k], i_Grants[k]);
          w_sat_hit      = w_sat_hit || (w_grant_nxt[k] == MAX);
`ifdef COPROC_PERF_MONITOR_STALL_EN
          w_stall_nxt[k] = f_sat_inc(r_stall[k], i_Requests[k] && !i_Grants[k]);
          w_sat_hit      = w_sat_hit || (w_stall_nxt[k] == MAX);
`endif
        end
        // A counter can only hold MAX after saturating during this run.
        w_overflow_nxt = r_overflow || w_sat_hit;
        if ($countones(i_Grants) > 1) w_grant_error_nxt = 1'b1;
        if (i_Done) begin
          w_state_nxt = ST_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (64'(r_cycles) == WD_LAST)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Readback selects from the post-update counter values. Once registered,
    // o_Read_Data then matches the counters held after the same edge.
    w_read_data = '0;
    if (32'(i_Read_Select) == 32'd0) w_read_data = w_cycles_nxt;
    if (32'(i_Read_Select) == 32'd1) w_read_data = w_reads_nxt;
    if (32'(i_Read_Select) == 32'd2) w_read_data = w_writes_nxt;
    for (int unsigned k = 0; k < N; k++) begin
      if (32'(i_Read_Select) == 3 + k) w_read_data = w_grant_nxt[k];
`ifdef COPROC_PERF_MONITOR_STALL_EN
      if (32'(i_Read_Select) == 3 + N + k) w_read_data = w_stall_nxt[k];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_cycles      <= '0;
      r_reads       <= '0;
      r_writes      <= '0;
      for (int unsigned k = 0; k < N; k++) begin
        r_grant[k] <= '0;
`ifdef COPROC_PERF_MONITOR_STALL_EN
        r_stall[k] <= '0;
`endif
      end
      r_timeout     <= 1'b0;
      r_overflow    <= 1'b0;
      r_grant_error <= 1'b0;
      r_read_data   <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cycles      <= w_cycles_nxt;
      r_reads       <= w_reads_nxt;
      r_writes      <= w_writes_nxt;
      r_grant       <= w_grant_nxt;
`ifdef COPROC_PERF_MONITOR_STALL_EN
      r_stall       <= w_stall_nxt;
`endif
      r_timeout     <= w_timeout_nxt;
      r_overflow    <= w_overflow_nxt;
      r_grant_error <= w_grant_error_nxt;
      r_read_data   <= w_read_data;
    end
  end

  assign o_Read_Data   = r_read_data;
  assign o_Busy        = (r_state == ST_RUN);
  assign o_Finished    = (r_state == ST_DONE);
  assign o_Timeout     = r_timeout;
  assign o_Overflow    = r_overflow;
  assign o_Grant_Error = r_grant_error;

endmodule
